// File: rtl/seg_scan_mux_pkg.sv
// Shared definitions for the 7-segment scan driver: segment bit order and
// the active-high hex font patterns.
package seg_scan_mux_pkg;

  // Segment vector order, MSB first: {g,f,e,d,c,b,a}; a lit segment is 1.
  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_t;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_A     = 7'h77;
  localparam seg_t SEG_B     = 7'h7C;
  localparam seg_t SEG_C     = 7'h39;
  localparam seg_t SEG_D     = 7'h5E;
  localparam seg_t SEG_E     = 7'h79;
  localparam seg_t SEG_F     = 7'h71;
  localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_scan_mux_font.sv
// Combinational hex nibble to 7-segment pattern, always active-high;
// the scan driver applies board polarity afterwards.
module hex_to_7seg_font
  import seg_scan_mux_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_t       o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Multi-digit 7-segment scan driver with per-frame input snapshot,
// leading-zero blanking and PWM brightness on the anodes.
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int BRIGHT_BITS = 4,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    refresh_clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp_in,
  input  logic [NUM_DIGITS-1:0]   i_digit_en,
  input  logic                    i_lzb_en,
  input  logic [BRIGHT_BITS-1:0]  i_brightness,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame_start
);

  localparam int                   DIG_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [BRIGHT_BITS-1:0] SLOT_MAX = '1;
  localparam logic [DIG_W-1:0]     LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);
  localparam logic                 INACT      = (ACTIVE_LOW != 0);

  logic [BRIGHT_BITS-1:0]  r_slot;
  logic [DIG_W-1:0]        r_digit;
  logic [4*NUM_DIGITS-1:0] r_valueSh;
  logic [NUM_DIGITS-1:0]   r_dpSh;
  logic [NUM_DIGITS-1:0]   r_enSh;
  logic                    r_lzbSh;
  logic [BRIGHT_BITS-1:0]  r_brightSh;

  logic                    w_frameEnd;
  logic [NUM_DIGITS-1:0]   w_lzBlank;
  logic [3:0]              w_nibble;
  logic                    w_blank;
  logic                    w_dpReq;
  logic [NUM_DIGITS-1:0]   w_anHot;
  seg_t                    w_font;
  logic [6:0]              w_segHi;

  assign w_frameEnd = (r_digit == LAST_DIGIT) && (r_slot == SLOT_MAX);

  // The digit counter wraps explicitly so non-power-of-two digit counts never
  // reach an unused index.
  always_ff @(posedge refresh_clk or posedge reset) begin
    if (reset) begin
      r_slot  <= '0;
      r_digit <= '0;
    end else begin
      r_slot <= r_slot + 1'b1;
      if (r_slot == SLOT_MAX)
        r_digit <= (r_digit == LAST_DIGIT) ? '0 : r_digit + 1'b1;
    end
  end

  always_ff @(posedge refresh_clk or posedge reset) begin
    if (reset) begin
      r_valueSh  <= '0;
      r_dpSh     <= '0;
      r_enSh     <= '0;
      r_lzbSh    <= 1'b0;
      r_brightSh <= '0;
    end else if (w_frameEnd) begin
      r_valueSh  <= i_value;
      r_dpSh     <= i_dp_in;
      r_enSh     <= i_digit_en;
      r_lzbSh    <= i_lzb_en;
      r_brightSh <= i_brightness;
    end
  end

  // Scan from the most significant digit; a digit is a leading zero until
  // the first non-zero nibble is seen. Digit 0 always shows.
  always_comb begin
    logic seen;
    seen      = 1'b0;
    w_lzBlank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (r_valueSh[4*i +: 4] != 4'h0)
        seen = 1'b1;
      w_lzBlank[i] = r_lzbSh && !seen && (i != 0);
    end
  end

  always_comb begin
    w_nibble = 4'h0;
    w_blank  = 1'b1;
    w_dpReq  = 1'b0;
    w_anHot  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_digit == DIG_W'(i)) begin
        w_nibble   = r_valueSh[4*i +: 4];
        w_blank    = !r_enSh[i] || w_lzBlank[i];
        w_dpReq    = r_dpSh[i];
        w_anHot[i] = (r_slot < r_brightSh);
      end
    end
  end

  hex_to_7seg_font u_font (
    .i_nibble (w_nibble),
    .o_seg    (w_font)
  );

  assign w_segHi = w_blank ? SEG_BLANK : w_font;

  always_ff @(posedge refresh_clk or posedge reset) begin
    if (reset) begin
      o_an          <= {NUM_DIGITS{INACT}};
      o_seg         <= {7{INACT}};
      o_dp          <= INACT;
      o_frame_start <= 1'b0;
    end else begin
      o_an          <= w_anHot ^ {NUM_DIGITS{INACT}};
      o_seg         <= w_segHi ^ {7{INACT}};
      o_dp          <= (w_dpReq && !w_blank) ^ INACT;
      o_frame_start <= (r_digit == '0) && (r_slot == '0);
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: an 8-digit active-low instance driven by
// directed vectors and a 6-digit active-high instance with fixed inputs.
module tb_seg_scan_mux;

  typedef struct {
    int          frame;
    string       name;
    logic [55:0] segs;
    logic [7:0]  dps;
    int          onCnt;
  } exp_t;

  logic        refreshClk = 1'b0;
  logic        reset      = 1'b1;

  logic [31:0] value      = '0;
  logic [7:0]  dpIn       = '0;
  logic [7:0]  digitEn    = '0;
  logic        lzbEn      = 1'b0;
  logic [3:0]  brightness = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frameStart;

  logic [23:0] value6      = 24'h9E_0B71;
  logic [5:0]  dpIn6       = 6'b000001;
  logic [5:0]  digitEn6    = 6'h3F;
  logic        lzbEn6      = 1'b0;
  logic [3:0]  brightness6 = 4'h3;
  logic [5:0]  an6;
  logic [6:0]  seg6;
  logic        dp6;
  logic        frameStart6;

  int checks = 0;
  int errors = 0;

  exp_t q8[$];
  exp_t q6[$];

  always #5 refreshClk = ~refreshClk;

  seg_scan_mux #(.NUM_DIGITS(8), .BRIGHT_BITS(4), .ACTIVE_LOW(1)) dut8 (
    .refresh_clk   (refreshClk),
    .reset         (reset),
    .i_value       (value),
    .i_dp_in       (dpIn),
    .i_digit_en    (digitEn),
    .i_lzb_en      (lzbEn),
    .i_brightness  (brightness),
    .o_an          (an),
    .o_seg         (seg),
    .o_dp          (dp),
    .o_frame_start (frameStart)
  );

  seg_scan_mux #(.NUM_DIGITS(6), .BRIGHT_BITS(4), .ACTIVE_LOW(0)) dut6 (
    .refresh_clk   (refreshClk),
    .reset         (reset),
    .i_value       (value6),
    .i_dp_in       (dpIn6),
    .i_digit_en    (digitEn6),
    .i_lzb_en      (lzbEn6),
    .i_brightness  (brightness6),
    .o_an          (an6),
    .o_seg         (seg6),
    .o_dp          (dp6),
    .o_frame_start (frameStart6)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor state for the 8-digit instance; one frame is gathered then scored.
  int         frameCount8 = 0;
  int         cyc8        = -1;
  int         since8      = 0;
  bit         afterReset8 = 1'b1;
  bit         badAn8      = 1'b0;
  bit         unstable8   = 1'b0;
  int         d8;
  logic [7:0] act8;
  int         onCnt8[8];
  logic [6:0] obsSeg8[8];
  logic       obsDp8[8];

  task automatic finishFrame8();
    exp_t e;
    while (q8.size() > 0 && q8[0].frame < frameCount8) begin
      e = q8.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s dut8: frame %0d never completed, reached frame %0d", e.name, e.frame, frameCount8);
    end
    if (q8.size() > 0 && q8[0].frame == frameCount8) begin
      e = q8.pop_front();
      checkOutput($sformatf("%s anode one-hot", e.name), 64'(badAn8), 64'(0));
      checkOutput($sformatf("%s seg stable", e.name), 64'(unstable8), 64'(0));
      for (int i = 0; i < 8; i++) begin
        checkOutput($sformatf("%s seg d%0d", e.name, i), 64'(obsSeg8[i]), 64'(e.segs[7*i +: 7]));
        checkOutput($sformatf("%s dp d%0d", e.name, i), 64'(obsDp8[i]), 64'(e.dps[i]));
        checkOutput($sformatf("%s on-cycles d%0d", e.name, i), 64'(onCnt8[i]), 64'(e.onCnt));
      end
    end
  endtask

  always @(negedge refreshClk) begin : monitor8
    if (reset) begin
      cyc8        = -1;
      afterReset8 = 1'b1;
    end else begin
      if (frameStart) begin
        if (!afterReset8)
          checkOutput("dut8 frame period", 64'(since8), 64'(128));
        afterReset8 = 1'b0;
        frameCount8++;
        cyc8      = 0;
        since8    = 0;
        badAn8    = 1'b0;
        unstable8 = 1'b0;
        for (int i = 0; i < 8; i++) onCnt8[i] = 0;
      end
      since8++;
      if (cyc8 >= 0) begin
        d8   = cyc8 / 16;
        act8 = ~an;
        if (act8 != 8'h00) begin
          if (act8 != (8'h01 << d8)) badAn8 = 1'b1;
          else onCnt8[d8]++;
        end
        if (cyc8 % 16 == 0) begin
          obsSeg8[d8] = seg;
          obsDp8[d8]  = dp;
        end else if (seg !== obsSeg8[d8] || dp !== obsDp8[d8]) begin
          unstable8 = 1'b1;
        end
        cyc8++;
        if (cyc8 == 128) begin
          finishFrame8();
          cyc8 = -1;
        end
      end
    end
  end

  // Monitor state for the 6-digit active-high instance.
  int         frameCount6 = 0;
  int         cyc6        = -1;
  int         since6      = 0;
  bit         afterReset6 = 1'b1;
  bit         badAn6      = 1'b0;
  int         d6;
  int         onCnt6[6];
  logic [6:0] obsSeg6[6];
  logic       obsDp6[6];

  task automatic finishFrame6();
    exp_t e;
    while (q6.size() > 0 && q6[0].frame < frameCount6) begin
      e = q6.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s dut6: frame %0d never completed, reached frame %0d", e.name, e.frame, frameCount6);
    end
    if (q6.size() > 0 && q6[0].frame == frameCount6) begin
      e = q6.pop_front();
      checkOutput($sformatf("%s anode one-hot", e.name), 64'(badAn6), 64'(0));
      for (int i = 0; i < 6; i++) begin
        checkOutput($sformatf("%s seg d%0d", e.name, i), 64'(obsSeg6[i]), 64'(e.segs[7*i +: 7]));
        checkOutput($sformatf("%s dp d%0d", e.name, i), 64'(obsDp6[i]), 64'(e.dps[i]));
        checkOutput($sformatf("%s on-cycles d%0d", e.name, i), 64'(onCnt6[i]), 64'(e.onCnt));
      end
    end
  endtask

  always @(negedge refreshClk) begin : monitor6
    if (reset) begin
      cyc6        = -1;
      afterReset6 = 1'b1;
    end else begin
      if (frameStart6) begin
        if (!afterReset6)
          checkOutput("dut6 frame period", 64'(since6), 64'(96));
        afterReset6 = 1'b0;
        frameCount6++;
        cyc6   = 0;
        since6 = 0;
        badAn6 = 1'b0;
        for (int i = 0; i < 6; i++) onCnt6[i] = 0;
      end
      since6++;
      if (cyc6 >= 0) begin
        d6 = cyc6 / 16;
        if (an6 != 6'h00) begin
          if (an6 != (6'h01 << d6)) badAn6 = 1'b1;
          else onCnt6[d6]++;
        end
        if (cyc6 % 16 == 0) begin
          obsSeg6[d6] = seg6;
          obsDp6[d6]  = dp6;
        end
        cyc6++;
        if (cyc6 == 96) begin
          finishFrame6();
          cyc6 = -1;
        end
      end
    end
  end

  task automatic waitFrameStart(output int n);
    bit seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge refreshClk);
      #1;
      if (frameStart) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL frame_start timeout: got no pulse in 400 cycles, expected one");
    end
    n = frameCount8;
  endtask

  // Inputs change at digit 3 of the current frame; they must only appear in
  // the following frame, which is the one the expectation is filed against.
  task automatic applyStimulus(input string name, input logic [31:0] val, input logic [7:0] dpv,
                               input logic [7:0] en, input logic lzb, input logic [3:0] br,
                               input logic [55:0] segs, input logic [7:0] dps, input int onCnt);
    int   n;
    exp_t e;
    waitFrameStart(n);
    repeat (48) @(negedge refreshClk);
    #1;
    value      = val;
    dpIn       = dpv;
    digitEn    = en;
    lzbEn      = lzb;
    brightness = br;
    e.frame = n + 1;
    e.name  = name;
    e.segs  = segs;
    e.dps   = dps;
    e.onCnt = onCnt;
    q8.push_back(e);
  endtask

  localparam logic [55:0] DARK8 = {8{7'h7F}};
  localparam logic [55:0] A5_8  = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12};
  localparam logic [55:0] V8SEG = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};

  initial begin : stimulus
    int   n;
    exp_t e;

    e.frame = 1; e.name = "dark8 after reset"; e.segs = DARK8; e.dps = 8'hFF; e.onCnt = 0;
    q8.push_back(e);
    e.frame = 1; e.name = "dark6 after reset"; e.segs = '0; e.dps = 8'h00; e.onCnt = 0;
    q6.push_back(e);
    e.segs = {14'h0, 7'h6F, 7'h79, 7'h3F, 7'h7C, 7'h07, 7'h06};
    e.dps = 8'h01; e.onCnt = 3;
    e.frame = 2; e.name = "six digit frame2"; q6.push_back(e);
    e.frame = 3; e.name = "six digit frame3"; q6.push_back(e);

    repeat (3) @(negedge refreshClk);
    #1;
    checkOutput("reset an8", 64'(an), 64'(8'hFF));
    checkOutput("reset seg8", 64'(seg), 64'(7'h7F));
    checkOutput("reset dp8", 64'(dp), 64'(1));
    checkOutput("reset frame_start8", 64'(frameStart), 64'(0));
    checkOutput("reset an6", 64'(an6), 64'(0));
    checkOutput("reset seg6", 64'(seg6), 64'(0));
    reset = 1'b0;

    applyStimulus("A5 plain", 32'h0000_00A5, 8'h00, 8'hFF, 1'b0, 4'hF, A5_8, 8'hFF, 15);
    applyStimulus("A5 lzb", 32'h0000_00A5, 8'h00, 8'hFF, 1'b1, 4'hF,
                  {{6{7'h7F}}, 7'h08, 7'h12}, 8'hFF, 15);
    applyStimulus("zero lzb", 32'h0000_0000, 8'h00, 8'hFF, 1'b1, 4'hF,
                  {{7{7'h7F}}, 7'h40}, 8'hFF, 15);
    applyStimulus("01000000 lzb", 32'h0100_0000, 8'h00, 8'hFF, 1'b1, 4'hF,
                  {7'h7F, 7'h79, {6{7'h40}}}, 8'hFF, 15);
    applyStimulus("bright0", 32'h0000_00A5, 8'h00, 8'hFF, 1'b0, 4'h0, A5_8, 8'hFF, 0);
    applyStimulus("bright1", 32'h0000_00A5, 8'h00, 8'hFF, 1'b0, 4'h1, A5_8, 8'hFF, 1);
    applyStimulus("bright8 en dp", 32'h0123_4567, 8'h81, 8'hF0, 1'b0, 4'h8,
                  {7'h40, 7'h79, 7'h24, 7'h30, {4{7'h7F}}}, 8'h7F, 8);
    applyStimulus("midframe change", 32'hFEDC_BA98, 8'h00, 8'hFF, 1'b0, 4'hC, V8SEG, 8'hFF, 12);

    // Let the mid-frame vector be scored, then hit reset at digit 4, slot 7.
    waitFrameStart(n);
    waitFrameStart(n);
    repeat (71) @(negedge refreshClk);
    #1;
    checkOutput("pre-reset an8", 64'(an), 64'(8'hEF));
    checkOutput("pre-reset seg8", 64'(seg), 64'(7'h46));
    reset = 1'b1;
    #1;
    checkOutput("async reset an8", 64'(an), 64'(8'hFF));
    checkOutput("async reset seg8", 64'(seg), 64'(7'h7F));
    checkOutput("async reset dp8", 64'(dp), 64'(1));
    checkOutput("async reset an6", 64'(an6), 64'(0));
    @(negedge refreshClk);
    #1;
    reset = 1'b0;
    n = frameCount8;
    e.frame = n + 1; e.name = "dark after midframe reset"; e.segs = DARK8; e.dps = 8'hFF; e.onCnt = 0;
    q8.push_back(e);
    e.frame = n + 2; e.name = "recapture after reset"; e.segs = V8SEG; e.dps = 8'hFF; e.onCnt = 12;
    q8.push_back(e);

    for (int k = 0; k < 600 && (q8.size() > 0 || q6.size() > 0); k++)
      @(negedge refreshClk);
    #1;
    if (q8.size() > 0 || q6.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d+%0d expectations left, expected 0", q8.size(), q6.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at 1ms, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
